// File: rtl/dvi_feeder_pkg.sv
// Shared state type, default frame geometry and index helper for the DVI pixel feeder.
package dvi_feeder_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } feeder_state_e;

  localparam int H_PAIRS_DEF    = 320;
  localparam int V_LINES_DEF    = 480;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int FRAME_PAIRS    = H_PAIRS_DEF * V_LINES_DEF;

  // Linear pair index with wrap at the end of the frame.
  function automatic int unsigned next_pair(input int unsigned idx, input int unsigned frame_pairs);
    if (idx >= frame_pairs - 32'd1) begin
      return 32'd0;
    end else begin
      return idx + 32'd1;
    end
  endfunction

endpackage

// File: rtl/dvi_feeder_checker.sv
// Simulation-only protocol checks on the feeder's frame buffer read interface.
module dvi_feeder_checker #(
  parameter int LVL_W = 4
) (
  input logic             clock,
  input logic             reset,
  input logic             mem_rd_valid,
  input logic [LVL_W-1:0] outstanding
);

  // Every returned word must answer a read that is still in flight.
  a_no_orphan_return : assert property (@(posedge clock) disable iff (reset)
    !(mem_rd_valid && (outstanding == {LVL_W{1'b0}})));

endmodule

// File: rtl/pixel_fifo.sv
// Synchronous show-ahead FIFO: head is valid whenever level is non-zero,
// otherwise EMPTY_VALUE is presented.
module pixel_fifo #(
  parameter int               WIDTH       = 64,
  parameter int               DEPTH       = 8,
  parameter logic [WIDTH-1:0] EMPTY_VALUE = {WIDTH{1'b0}}
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       push_data,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] level_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (level_r == {LVL_W{1'b0}});
  assign full_s    = (level_r == LVL_W'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full_s || do_pop_s);
  assign level     = level_r;
  assign head      = empty ? EMPTY_VALUE : mem_r[rd_ptr_r];

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (do_push_s && !clear) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; clear beats any push or pop on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      level_r  <= {LVL_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      level_r <= level_r + LVL_W'(do_push_s) - LVL_W'(do_pop_s);
    end
  end

endmodule

// File: rtl/dvi_pixel_feeder.sv
// Prefetches frame buffer words into a show-ahead FIFO and hands them to the DVI
// block on request; walks the frame linearly and restarts on frame_start.
module dvi_pixel_feeder
  import dvi_feeder_pkg::*;
#(
  parameter int          H_PAIRS         = H_PAIRS_DEF,
  parameter int          V_LINES         = V_LINES_DEF,
  parameter int          FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter int          ADDR_W          = 18,
  parameter int          FB_BASE         = 0,
  parameter logic [63:0] UNDERFLOW_COLOR = 64'h0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        request,
  output logic [63:0]                 data,
  output logic                        mem_rd_en,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_rd_valid,
  input  logic [63:0]                 mem_rd_data,
  output logic                        underflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned FRAME_LEN = H_PAIRS * V_LINES;
  localparam int          IDX_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int          LVL_W     = $clog2(FIFO_DEPTH) + 1;

  feeder_state_e    state_r;
  feeder_state_e    state_next_s;
  logic [IDX_W-1:0] pair_idx_r;
  logic [LVL_W-1:0] outstanding_r;
  logic [LVL_W:0]   credit_sum_s;
  logic             run_s;
  logic             ret_s;
  logic             issue_s;
  logic             push_s;
  logic             pop_s;
  logic             empty_s;

  // frame_start overrides any RUN activity on the edge where it is seen.
  assign run_s        = (state_r == RUN) && !frame_start;
  assign ret_s        = mem_rd_valid && (outstanding_r != {LVL_W{1'b0}});
  assign credit_sum_s = {1'b0, fifo_level} + {1'b0, outstanding_r};
  assign issue_s      = run_s && (credit_sum_s < (LVL_W + 1)'(FIFO_DEPTH));
  assign push_s       = run_s && ret_s;
  assign pop_s        = run_s && request && !empty_s;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FLUSH holds until every in-flight read has come back and been dropped.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (frame_start) state_next_s = FLUSH;
        else             state_next_s = RUN;
      end
      FLUSH: begin
        if (frame_start)                              state_next_s = FLUSH;
        else if (outstanding_r == {LVL_W{1'b0}})      state_next_s = RUN;
        else                                          state_next_s = FLUSH;
      end
      default: state_next_s = RUN;
    endcase
  end

  // Read issue, address walk, credit count and sticky underflow.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pair_idx_r    <= {IDX_W{1'b0}};
      outstanding_r <= {LVL_W{1'b0}};
      mem_rd_en     <= 1'b0;
      mem_addr      <= ADDR_W'(FB_BASE);
      underflow     <= 1'b0;
    end else begin
      mem_rd_en <= issue_s;
      if (issue_s) begin
        mem_addr <= ADDR_W'(FB_BASE) + ADDR_W'(pair_idx_r);
      end
      if (frame_start) begin
        pair_idx_r <= {IDX_W{1'b0}};
      end else if (issue_s) begin
        pair_idx_r <= IDX_W'(next_pair(32'(pair_idx_r), FRAME_LEN));
      end
      outstanding_r <= outstanding_r + LVL_W'(issue_s) - LVL_W'(ret_s);
      if (run_s && request && empty_s) begin
        underflow <= 1'b1;
      end
    end
  end

  pixel_fifo #(
    .WIDTH      (64),
    .DEPTH      (FIFO_DEPTH),
    .EMPTY_VALUE(UNDERFLOW_COLOR)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .clear    (frame_start),
    .push     (push_s),
    .pop      (pop_s),
    .push_data(mem_rd_data),
    .head     (data),
    .level    (fifo_level),
    .empty    (empty_s)
  );

  dvi_feeder_checker #(
    .LVL_W(LVL_W)
  ) u_chk (
    .clock       (clock),
    .reset       (reset),
    .mem_rd_valid(mem_rd_valid),
    .outstanding (outstanding_r)
  );

endmodule

// File: tb/tb_dvi_pixel_feeder.sv
// Self-checking bench: scenario table, directed corner sequences and a randomized
// run, all checked against a queue-based reference model of the feeder.
module tb_dvi_pixel_feeder;

  localparam int FRAME   = 320 * 480;
  localparam int DEPTH   = 8;
  localparam int FB_BASE = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start, request, mem_rd_valid, mem_rd_en, underflow;
  logic [63:0] mem_rd_data, data;
  logic [17:0] mem_addr;
  logic [3:0]  fifo_level;

  logic        s_fs, s_req, s_valid, s_en, s_uf;
  logic [63:0] s_rdata, s_data;
  logic [17:0] s_addr;
  logic [3:0]  s_level;

  always #5 clock = ~clock;

  dvi_pixel_feeder u_dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .request(request),
    .data(data), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .underflow(underflow), .fifo_level(fifo_level)
  );

  dvi_pixel_feeder #(.H_PAIRS(4), .V_LINES(2)) u_small (
    .clock(clock), .reset(reset), .frame_start(s_fs), .request(s_req),
    .data(s_data), .mem_rd_en(s_en), .mem_addr(s_addr),
    .mem_rd_valid(s_valid), .mem_rd_data(s_rdata),
    .underflow(s_uf), .fifo_level(s_level)
  );

  typedef struct { int due; int addr; } rd_t;
  typedef struct {
    int lat; int ncyc; int req_start; int req_period;
    int exp_level; int exp_uf; int exp_issues; int exp_head;
  } scen_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat_lo = 3, lat_hi = 3;
  int issues;
  rd_t mq[$];
  bit  s_pend;
  int  s_pend_addr;
  int  s_addrs[$];

  // Reference model state.
  logic [63:0] q_m[$];
  int out_m, idx_m, addr_m;
  bit flush_m, uf_m, en_m;

  function automatic logic [63:0] word(input int a);
    return {16'hC0DE, 30'(a), 18'(~a)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q_m.delete();
    out_m = 0; idx_m = 0; addr_m = FB_BASE;
    flush_m = 1'b0; uf_m = 1'b0; en_m = 1'b0;
  endtask

  // One clock edge of the feeder, from its behavioural rules.
  task automatic model_step(input bit req, input bit fs, input bit rv, input logic [63:0] rd);
    int  lvl0, out0;
    bit  issue;
    lvl0  = q_m.size();
    out0  = out_m;
    issue = !fs && !flush_m && (lvl0 + out0 < DEPTH);
    if (rv && out_m > 0) out_m--;
    if (fs) begin
      q_m.delete(); idx_m = 0; flush_m = 1'b1;
    end else if (flush_m) begin
      if (out0 == 0) flush_m = 1'b0;
    end else begin
      if (req) begin
        if (lvl0 > 0) void'(q_m.pop_front());
        else          uf_m = 1'b1;
      end
      if (rv) q_m.push_back(rd);
    end
    en_m = issue;
    if (issue) begin
      addr_m = FB_BASE + idx_m;
      idx_m  = (idx_m + 1) % FRAME;
      out_m++;
    end
  endtask

  // Drive one cycle at negedge, clock it, then compare at the next negedge.
  task automatic tick(input bit req, input bit fs);
    bit          rv;
    logic [63:0] rd, exp_data;
    rv = 1'b0;
    rd = {$urandom, $urandom};
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rv = 1'b1;
      rd = word(mq[0].addr);
      void'(mq.pop_front());
    end
    mem_rd_valid = rv; mem_rd_data = rd; request = req; frame_start = fs;
    s_valid = s_pend; s_rdata = word(s_pend_addr);
    model_step(req, fs, rv, rd);
    @(posedge clock);
    cyc++;
    @(negedge clock);
    exp_data = (q_m.size() > 0) ? q_m[0] : 64'h0;
    chk("data", data, exp_data);
    chk("fifo_level", fifo_level, q_m.size());
    chk("underflow", underflow, uf_m);
    chk("mem_rd_en", mem_rd_en, en_m);
    chk("mem_addr", mem_addr, addr_m);
    if (mem_rd_en) begin
      mq.push_back('{cyc + $urandom_range(lat_hi, lat_lo), int'(mem_addr)});
      issues++;
    end
    s_pend = s_en;
    s_pend_addr = int'(s_addr);
    if (s_en) s_addrs.push_back(int'(s_addr));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    request = 1'b0; frame_start = 1'b0; mem_rd_valid = 1'b0; s_valid = 1'b0;
    #1;
    chk("rst_data", data, 64'h0);
    chk("rst_level", fifo_level, 64'd0);
    chk("rst_underflow", underflow, 64'd0);
    chk("rst_rd_en", mem_rd_en, 64'd0);
    chk("rst_addr", mem_addr, 64'(FB_BASE));
    mq.delete(); s_addrs.delete(); s_pend = 1'b0; issues = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick(1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    scen_t scen[4];
    int    n, npop;
    bit    r;
    reset = 1'b0; request = 1'b0; frame_start = 1'b0; mem_rd_valid = 1'b0;
    mem_rd_data = 64'h0; s_fs = 1'b0; s_req = 1'b1; s_valid = 1'b0; s_rdata = 64'h0;
    scen[0] = '{3, 30, 0, 0, 8, 0, 8, 0};
    scen[1] = '{10, 30, 0, 1, -1, 1, -1, -1};
    scen[2] = '{2, 5, 0, 0, 3, 0, 6, 0};
    scen[3] = '{1, 40, 12, 1, -1, 0, -1, -1};
    #3;

    for (int s = 0; s < 4; s++) begin
      lat_lo = scen[s].lat; lat_hi = scen[s].lat;
      do_reset();
      for (int c = 0; c < scen[s].ncyc; c++) begin
        r = (scen[s].req_period != 0) && (c >= scen[s].req_start) &&
            ((c - scen[s].req_start) % scen[s].req_period == 0);
        tick(r, 1'b0);
      end
      if (scen[s].exp_level >= 0) chk($sformatf("scen%0d_level", s), fifo_level, 64'(scen[s].exp_level));
      chk($sformatf("scen%0d_underflow", s), underflow, 64'(scen[s].exp_uf));
      if (scen[s].exp_issues >= 0) chk($sformatf("scen%0d_issues", s), 64'(issues), 64'(scen[s].exp_issues));
      if (scen[s].exp_head >= 0) chk($sformatf("scen%0d_head", s), data, word(scen[s].exp_head));
    end

    // Fill, then pop every other cycle: stream must be addresses 0..319.
    lat_lo = 3; lat_hi = 3;
    do_reset();
    repeat (20) tick(1'b0, 1'b0);
    npop = 0;
    for (int c = 0; c < 640; c++) begin
      r = (c % 2 == 0);
      if (r) begin
        chk("seq_data", data, word(npop));
        npop++;
      end
      tick(r, 1'b0);
    end
    chk("seq_pops", 64'(npop), 64'd320);
    chk("seq_underflow", underflow, 64'd0);

    // frame_start with 5 buffered words and 3 reads in flight.
    lat_lo = 6; lat_hi = 6;
    do_reset();
    n = 0;
    while (!(q_m.size() == 5 && out_m == 3) && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("fs_setup_level", fifo_level, 64'd5);
    tick(1'b0, 1'b1);
    chk("fs_level", fifo_level, 64'd0);
    chk("fs_data", data, 64'h0);
    n = 0;
    while (flush_m && n < 20) begin
      chk("flush_no_issue", mem_rd_en, 64'd0);
      tick(1'b1, 1'b0);
      n++;
    end
    chk("flush_underflow", underflow, 64'd0);
    n = 0;
    while (!mem_rd_en && n < 10) begin
      tick(1'b0, 1'b0);
      n++;
    end
    chk("post_fs_en", mem_rd_en, 64'd1);
    chk("post_fs_addr", mem_addr, 64'(FB_BASE));
    chk("post_fs_level", fifo_level, 64'd0);

    // Small frame (4x2): issue addresses wrap 0..7 then 0 without frame_start.
    lat_lo = 2; lat_hi = 2;
    do_reset();
    repeat (30) tick(1'b0, 1'b0);
    chk("small_count", 64'(s_addrs.size() >= 12), 64'd1);
    if (s_addrs.size() >= 12) begin
      for (int i = 0; i < 12; i++) chk($sformatf("small_addr%0d", i), 64'(s_addrs[i]), 64'(i % 8));
    end
    chk("small_underflow", s_uf, 64'd1);

    // Asynchronous reset in the middle of a read burst.
    lat_lo = 4; lat_hi = 4;
    do_reset();
    repeat (5) tick(1'b0, 1'b0);
    chk("pre_rst_rd_en", mem_rd_en, 64'd1);
    #2;
    do_reset();
    chk("rst_first_en", mem_rd_en, 64'd1);
    chk("rst_first_addr", mem_addr, 64'(FB_BASE));

    // Randomized traffic with variable in-order memory latency.
    lat_lo = 1; lat_hi = 6;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      tick($urandom_range(9, 0) < 6, $urandom_range(149, 0) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
